bod_event_ctrl: RTL and testbench



---
 rtl/bod_pkg.sv | 22 ++
 rtl/bod_debounce.sv | 40 ++++
 rtl/bod_event_ctrl.sv | 118 +++++++++++
 tb/tb_bod_event_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bod_pkg.sv
// Shared types and defaults for the brown-out event controller and its debouncers.
package bod_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    WARN    = 2'd1,
    CRIT    = 2'd2,
    RECOVER = 2'd3
  } bod_state_t;

  localparam int DEB_CNT_DEF     = 4;
  localparam int DEB_W_DEF       = 4;
  localparam int HOLDOFF_CYC_DEF = 1000;
  localparam int HOLD_W_DEF      = 16;
  localparam int EVT_W_DEF       = 8;

  // A CRIT entry is any step into CRIT from a different state.
  function automatic logic is_crit_entry(input bod_state_t cur, input bod_state_t nxt);
    return (nxt == CRIT) && (cur != CRIT);
  endfunction

endpackage

// File: rtl/bod_debounce.sv
// Sample-qualified debouncer: the filtered flag flips only after DEB_CNT
// consecutive strobes whose raw value disagrees with it.
module bod_debounce
  import bod_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEF,
  parameter int DEB_W   = DEB_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_valid,
  input  logic raw,
  output logic filtered
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  logic [DEB_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (sample_valid) begin
      if (raw != filtered) begin
        if (cnt == DEB_LAST) begin
          filtered <= ~filtered;
          cnt      <= '0;
        end else begin
          cnt <= cnt + DEB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/bod_event_ctrl.sv
// Brown-out event controller: debounced warn/crit flags drive the NORMAL/WARN/CRIT/RECOVER
// FSM, a sticky warn interrupt, reset request and CRIT counter. BOD_TIMESTAMP_EN adds last_crit_ts.
module bod_event_ctrl
  import bod_pkg::*;
#(
  parameter int DEB_CNT     = DEB_CNT_DEF,
  parameter int DEB_W       = DEB_W_DEF,
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
  parameter int HOLD_W      = HOLD_W_DEF,
  parameter int EVT_W       = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic             bod_warn_in,
  input  logic             bod_crit_in,
  input  logic             irq_ack,
  input  logic             clear_cnt,
  output logic [1:0]       bod_state,
  output logic             irq_warn,
  output logic             bod_rst_req,
  output logic [EVT_W-1:0] event_cnt
`ifdef BOD_TIMESTAMP_EN
  ,
  output logic [31:0]      last_crit_ts
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYC - 1);
  localparam logic [EVT_W-1:0]  EVT_MAX   = '1;

  logic              eff_warn;
  logic              fw;
  logic              fc;
  bod_state_t        state;
  bod_state_t        next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              crit_entry;
  logic              irq_set;

  // Crit below thresh2 implies below thresh1, so crit also counts as warn.
  assign eff_warn = bod_warn_in | bod_crit_in;

  bod_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_warn (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .raw          (eff_warn),
    .filtered     (fw)
  );

  bod_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_crit (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .raw          (bod_crit_in),
    .filtered     (fc)
  );

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      NORMAL:  if (fc) next_state = CRIT; else if (fw) next_state = WARN;
      WARN:    if (fc) next_state = CRIT; else if (!fw) next_state = NORMAL;
      CRIT:    if (!fc) next_state = RECOVER;
      RECOVER: begin
        if (fc)                         next_state = CRIT;
        else if (hold_cnt == HOLD_LAST) next_state = fw ? WARN : NORMAL;
      end
      default: next_state = NORMAL;
    endcase
  end

  assign crit_entry = is_crit_entry(state, next_state);
  assign irq_set    = (state == NORMAL) && (next_state != NORMAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NORMAL;
      hold_cnt    <= '0;
      bod_rst_req <= 1'b0;
      irq_warn    <= 1'b0;
      event_cnt   <= '0;
    end else begin
      state       <= next_state;
      bod_rst_req <= (next_state == CRIT);

      // Held at zero while in CRIT so every RECOVER visit starts a fresh hold-off.
      if (state == CRIT)         hold_cnt <= '0;
      else if (state == RECOVER) hold_cnt <= hold_cnt + HOLD_W'(1);

      if (irq_set)      irq_warn <= 1'b1;
      else if (irq_ack) irq_warn <= 1'b0;

      if (clear_cnt)                           event_cnt <= crit_entry ? EVT_W'(1) : '0;
      else if (crit_entry && event_cnt != EVT_MAX) event_cnt <= event_cnt + EVT_W'(1);
    end
  end

  assign bod_state = state;

`ifdef BOD_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt       <= '0;
      last_crit_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (crit_entry) last_crit_ts <= ts_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_bod_event_ctrl.sv
// Directed bench for bod_event_ctrl with DEB_CNT=4, HOLDOFF_CYC=20 and a strobe every 3 cycles.
module tb_bod_event_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic       bod_warn_in;
  logic       bod_crit_in;
  logic       irq_ack;
  logic       clear_cnt;
  logic [1:0] bod_state;
  logic       irq_warn;
  logic       bod_rst_req;
  logic [7:0] event_cnt;
`ifdef BOD_TIMESTAMP_EN
  logic [31:0] last_crit_ts;
  int unsigned cyc;
`endif

  int passed = 0;
  int total  = 0;

  localparam logic [1:0] S_NORMAL  = 2'd0;
  localparam logic [1:0] S_WARN    = 2'd1;
  localparam logic [1:0] S_CRIT    = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  bod_event_ctrl #(
    .DEB_CNT     (4),
    .DEB_W       (4),
    .HOLDOFF_CYC (20),
    .HOLD_W      (16),
    .EVT_W       (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .bod_warn_in  (bod_warn_in),
    .bod_crit_in  (bod_crit_in),
    .irq_ack      (irq_ack),
    .clear_cnt    (clear_cnt),
    .bod_state    (bod_state),
    .irq_warn     (irq_warn),
    .bod_rst_req  (bod_rst_req),
    .event_cnt    (event_cnt)
`ifdef BOD_TIMESTAMP_EN
    ,
    .last_crit_ts (last_crit_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BOD_TIMESTAMP_EN
  // Edges seen since reset release; the DUT latches the pre-edge value.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end
`endif

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic w, input logic c);
    bod_warn_in = w;
    bod_crit_in = c;
  endtask

  task automatic strobe(input int n = 1);
    repeat (n) begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      tick(2);
    end
  endtask

  // Single strobe edge only; the filtered flag has just updated on return.
  task automatic last_strobe();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0);
    sample_valid = 1'b0;
    irq_ack = 1'b0;
    clear_cnt = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick();
    total++; if (bod_state !== S_NORMAL) $display("FAIL reset_state: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
    total++; if (irq_warn !== 1'b0) $display("FAIL reset_irq: got %0b expected 0", irq_warn); else passed++;
    total++; if (bod_rst_req !== 1'b0) $display("FAIL reset_rst_req: got %0b expected 0", bod_rst_req); else passed++;
    total++; if (event_cnt !== 8'd0) $display("FAIL reset_event_cnt: got %0d expected 0", event_cnt); else passed++;
  endtask

  task automatic test_short_warn();
    set_in(1'b1, 1'b0);
    strobe(3);
    set_in(1'b0, 1'b0);
    strobe(1);
    total++; if (bod_state !== S_NORMAL) $display("FAIL short_warn_state: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
    total++; if (irq_warn !== 1'b0) $display("FAIL short_warn_irq: got %0b expected 0", irq_warn); else passed++;
    // A second 3-strobe burst must not flip: the agreeing strobe cleared the count.
    set_in(1'b1, 1'b0);
    strobe(3);
    set_in(1'b0, 1'b0);
    strobe(1);
    total++; if (bod_state !== S_NORMAL) $display("FAIL short_warn_restart: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
  endtask

  task automatic test_warn_irq();
    set_in(1'b1, 1'b0);
    strobe(3);
    last_strobe();
    total++; if (bod_state !== S_NORMAL) $display("FAIL warn_latency_early: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (bod_state !== S_WARN) $display("FAIL warn_state: got %0d expected %0d", bod_state, S_WARN); else passed++;
    total++; if (irq_warn !== 1'b1) $display("FAIL warn_irq_set_wins: got %0b expected 1", irq_warn); else passed++;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (irq_warn !== 1'b0) $display("FAIL warn_irq_ack: got %0b expected 0", irq_warn); else passed++;
    total++; if (bod_state !== S_WARN) $display("FAIL warn_state_after_ack: got %0d expected %0d", bod_state, S_WARN); else passed++;
    set_in(1'b0, 1'b0);
    strobe(4);
    total++; if (bod_state !== S_NORMAL) $display("FAIL warn_release: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
    total++; if (irq_warn !== 1'b0) $display("FAIL warn_release_irq: got %0b expected 0", irq_warn); else passed++;
  endtask

  task automatic test_crit_cycle();
    set_in(1'b0, 1'b1);
    strobe(3);
    last_strobe();
    total++; if (bod_state !== S_NORMAL) $display("FAIL crit_latency_early: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
    tick();
    total++; if (bod_state !== S_CRIT) $display("FAIL crit_state: got %0d expected %0d", bod_state, S_CRIT); else passed++;
    total++; if (bod_rst_req !== 1'b1) $display("FAIL crit_rst_req: got %0b expected 1", bod_rst_req); else passed++;
    total++; if (event_cnt !== 8'd1) $display("FAIL crit_event_cnt: got %0d expected 1", event_cnt); else passed++;
    total++; if (irq_warn !== 1'b1) $display("FAIL crit_irq: got %0b expected 1", irq_warn); else passed++;
`ifdef BOD_TIMESTAMP_EN
    total++; if (last_crit_ts !== cyc - 1) $display("FAIL crit_timestamp: got %0d expected %0d", last_crit_ts, cyc - 1); else passed++;
`endif
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    set_in(1'b0, 1'b0);
    strobe(3);
    last_strobe();
    total++; if (bod_state !== S_CRIT) $display("FAIL crit_exit_early: got %0d expected %0d", bod_state, S_CRIT); else passed++;
    tick();
    total++; if (bod_state !== S_RECOVER) $display("FAIL recover_state: got %0d expected %0d", bod_state, S_RECOVER); else passed++;
    total++; if (bod_rst_req !== 1'b0) $display("FAIL recover_rst_req: got %0b expected 0", bod_rst_req); else passed++;
    tick(19);
    total++; if (bod_state !== S_RECOVER) $display("FAIL holdoff_not_done: got %0d expected %0d", bod_state, S_RECOVER); else passed++;
    tick();
    total++; if (bod_state !== S_NORMAL) $display("FAIL holdoff_done: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
    total++; if (irq_warn !== 1'b0) $display("FAIL recover_normal_irq: got %0b expected 0", irq_warn); else passed++;
  endtask

  task automatic test_recover_reentry();
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    total++; if (event_cnt !== 8'd0) $display("FAIL clear_alone: got %0d expected 0", event_cnt); else passed++;
    irq_ack = 1'b1;
    set_in(1'b0, 1'b1);
    strobe(4);
    irq_ack = 1'b0;
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    total++; if (event_cnt !== 8'd1) $display("FAIL reentry_first: got %0d expected 1", event_cnt); else passed++;
    set_in(1'b0, 1'b0);
    strobe(3);
    last_strobe();
    tick();
    set_in(1'b0, 1'b1);
    strobe(3);
    last_strobe();
    total++; if (bod_state !== S_RECOVER) $display("FAIL reentry_hold10: got %0d expected %0d", bod_state, S_RECOVER); else passed++;
    tick();
    total++; if (bod_state !== S_CRIT) $display("FAIL reentry_state: got %0d expected %0d", bod_state, S_CRIT); else passed++;
    total++; if (event_cnt !== 8'd2) $display("FAIL reentry_event_cnt: got %0d expected 2", event_cnt); else passed++;
    // Leave with warn still present: hold-off restarts, then exit to WARN.
    set_in(1'b1, 1'b0);
    strobe(3);
    last_strobe();
    tick();
    tick(19);
    total++; if (bod_state !== S_RECOVER) $display("FAIL holdoff_restart: got %0d expected %0d", bod_state, S_RECOVER); else passed++;
    tick();
    total++; if (bod_state !== S_WARN) $display("FAIL recover_to_warn: got %0d expected %0d", bod_state, S_WARN); else passed++;
    total++; if (irq_warn !== 1'b0) $display("FAIL recover_warn_irq: got %0b expected 0", irq_warn); else passed++;
    set_in(1'b0, 1'b0);
    strobe(4);
  endtask

  task automatic test_saturation();
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    set_in(1'b0, 1'b1);
    strobe(4);
    for (int i = 0; i < 254; i++) begin
      set_in(1'b0, 1'b0);
      strobe(4);
      set_in(1'b0, 1'b1);
      strobe(4);
    end
    total++; if (event_cnt !== 8'd255) $display("FAIL sat_preload: got %0d expected 255", event_cnt); else passed++;
    set_in(1'b0, 1'b0);
    strobe(4);
    set_in(1'b0, 1'b1);
    strobe(4);
    total++; if (bod_state !== S_CRIT) $display("FAIL sat_state: got %0d expected %0d", bod_state, S_CRIT); else passed++;
    total++; if (event_cnt !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", event_cnt); else passed++;
    set_in(1'b0, 1'b0);
    strobe(4);
    set_in(1'b0, 1'b1);
    strobe(3);
    last_strobe();
    clear_cnt = 1'b1;
    tick();
    clear_cnt = 1'b0;
    total++; if (bod_state !== S_CRIT) $display("FAIL clear_entry_state: got %0d expected %0d", bod_state, S_CRIT); else passed++;
    total++; if (event_cnt !== 8'd1) $display("FAIL clear_with_entry: got %0d expected 1", event_cnt); else passed++;
  endtask

  task automatic test_reset_mid_recover();
    set_in(1'b0, 1'b0);
    strobe(3);
    last_strobe();
    tick(4);
    total++; if (bod_state !== S_RECOVER) $display("FAIL pre_reset_state: got %0d expected %0d", bod_state, S_RECOVER); else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (bod_state !== S_NORMAL) $display("FAIL async_reset_state: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
    total++; if (irq_warn !== 1'b0) $display("FAIL async_reset_irq: got %0b expected 0", irq_warn); else passed++;
    total++; if (bod_rst_req !== 1'b0) $display("FAIL async_reset_rst_req: got %0b expected 0", bod_rst_req); else passed++;
    total++; if (event_cnt !== 8'd0) $display("FAIL async_reset_event_cnt: got %0d expected 0", event_cnt); else passed++;
`ifdef BOD_TIMESTAMP_EN
    total++; if (last_crit_ts !== 32'd0) $display("FAIL async_reset_ts: got %0d expected 0", last_crit_ts); else passed++;
`endif
    tick(2);
    rst_n = 1'b1;
    strobe(2);
    total++; if (bod_state !== S_NORMAL) $display("FAIL post_reset_state: got %0d expected %0d", bod_state, S_NORMAL); else passed++;
  endtask

  initial begin
    test_reset();
    test_short_warn();
    test_warn_irq();
    test_crit_cycle();
    test_recover_reentry();
    test_saturation();
    test_reset_mid_recover();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
